dm_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters:
  - the CPU data port;
  - a debug/loader port used to preload or inspect memory while the core runs.
- Decides one winner per cycle with round-robin plus optional burst lock.
- Muxes the winner's address, data, write and memOp onto the memory.
- Stalls the CPU when it loses.
- Sits between the CPU/debug masters and the data memory, inside the top-level computer.

---
 rtl/dm_arb_pkg.sv | 14 +
 rtl/dm_arb_sel.sv | 40 ++++
 rtl/dm_arbiter.sv | 126 ++++++++++++
 tb/tb_dm_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared owner encoding and memory access size codes for the data-memory arbiter
package dm_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    localparam logic [1:0] MEMOP_BYTE = 2'd0;
    localparam logic [1:0] MEMOP_HALF = 2'd1;
    localparam logic [1:0] MEMOP_WORD = 2'd2;

endpackage

// File: rtl/dm_arb_sel.sv
// rtl/dm_arb_sel.sv - combinational winner selection: burst-lock hold, then round-robin
module dm_arb_sel
    import dm_arb_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int BCNT_W    = $clog2(MAX_BURST)
) (
    input  owner_t            owner,
    input  owner_t            last,
    input  logic [BCNT_W-1:0] bcnt,
    input  logic              cpu_req,
    input  logic              cpu_lock,
    input  logic              dbg_req,
    input  logic              dbg_lock,
    output owner_t            winner
);

    localparam logic [BCNT_W-1:0] CAP = BCNT_W'(MAX_BURST - 1);

    logic at_cap;

    assign at_cap = (bcnt == CAP);

    // At the cap a locked owner only keeps the memory if nobody else is waiting.
    always_comb begin
        winner = OWN_NONE;
        if (owner == OWN_CPU && cpu_req && cpu_lock && (!at_cap || !dbg_req)) begin
            winner = OWN_CPU;
        end else if (owner == OWN_DBG && dbg_req && dbg_lock && (!at_cap || !cpu_req)) begin
            winner = OWN_DBG;
        end else if (cpu_req && dbg_req) begin
            winner = (last == OWN_CPU) ? OWN_DBG : OWN_CPU;
        end else if (cpu_req) begin
            winner = OWN_CPU;
        end else if (dbg_req) begin
            winner = OWN_DBG;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - CPU/debug data-memory arbiter with burst lock; DM_ARB_STATS_EN adds a CPU stall counter
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [1:0]        cpu_memop,
    input  logic              cpu_lock,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic [1:0]        dbg_memop,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic [DATA_W-1:0] rdata,
    output logic              dm_wr,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_din,
    output logic [1:0]        dm_memop,
    input  logic [DATA_W-1:0] dm_dout,
    output logic [15:0]       stall_cnt
);

    localparam int                BCNT_W = $clog2(MAX_BURST);
    localparam logic [BCNT_W-1:0] CAP    = BCNT_W'(MAX_BURST - 1);

    owner_t            owner;
    owner_t            last;
    logic [BCNT_W-1:0] bcnt;
    owner_t            sel_winner;
    owner_t            winner;
    logic              win_lock;

    dm_arb_sel #(
        .MAX_BURST (MAX_BURST),
        .BCNT_W    (BCNT_W)
    ) u_sel (
        .owner    (owner),
        .last     (last),
        .bcnt     (bcnt),
        .cpu_req  (cpu_req),
        .cpu_lock (cpu_lock),
        .dbg_req  (dbg_req),
        .dbg_lock (dbg_lock),
        .winner   (sel_winner)
    );

    // Grants and the memory port are forced idle for as long as reset is held.
    assign winner   = rstn ? sel_winner : OWN_NONE;
    assign win_lock = (winner == OWN_CPU && cpu_lock) || (winner == OWN_DBG && dbg_lock);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner <= OWN_NONE;
            last  <= OWN_DBG;
            bcnt  <= '0;
        end else begin
            owner <= winner;
            if (winner != OWN_NONE) begin
                last <= winner;
            end
            if (winner != OWN_NONE && winner == owner && win_lock) begin
                bcnt <= (bcnt == CAP) ? bcnt : bcnt + 1'b1;
            end else begin
                bcnt <= '0;
            end
        end
    end

    always_comb begin
        cpu_gnt  = 1'b0;
        dbg_gnt  = 1'b0;
        dm_wr    = 1'b0;
        dm_addr  = '0;
        dm_din   = '0;
        dm_memop = '0;
        case (winner)
            OWN_CPU: begin
                cpu_gnt  = 1'b1;
                dm_wr    = cpu_we;
                dm_addr  = cpu_addr;
                dm_din   = cpu_wdata;
                dm_memop = cpu_memop;
            end
            OWN_DBG: begin
                dbg_gnt  = 1'b1;
                dm_wr    = dbg_we;
                dm_addr  = dbg_addr;
                dm_din   = dbg_wdata;
                dm_memop = dbg_memop;
            end
            default: ;
        endcase
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;
    assign rdata     = dm_dout;

`ifdef DM_ARB_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_q <= '0;
        end else if (cpu_stall && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - randomized self-checking bench for dm_arbiter against a behavioural arbitration model
module tb_dm_arbiter;
    import dm_arb_pkg::*;

    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;
`ifdef DM_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rstn;
    logic              cpu_req, cpu_we, cpu_lock, dbg_req, dbg_we, dbg_lock;
    logic [ADDR_W-1:0] cpu_addr, dbg_addr;
    logic [DATA_W-1:0] cpu_wdata, dbg_wdata, dm_dout;
    logic [1:0]        cpu_memop, dbg_memop;
    logic              cpu_gnt, cpu_stall, dbg_gnt, dm_wr;
    logic [DATA_W-1:0] rdata, dm_din;
    logic [ADDR_W-1:0] dm_addr;
    logic [1:0]        dm_memop;
    logic [15:0]       stall_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: 0 = nobody, 1 = CPU, 2 = debug port.
    int m_owner, m_last, m_held, m_stall;
    logic [1:0] obs_gnt;

    always #5 clk = ~clk;

    dm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rstn(rstn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_memop(cpu_memop), .cpu_lock(cpu_lock), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_memop(dbg_memop), .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt),
        .rdata(rdata), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_din(dm_din),
        .dm_memop(dm_memop), .dm_dout(dm_dout), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_winner();
        bit req[3];
        bit lck[3];
        req[1] = cpu_req; req[2] = dbg_req;
        lck[1] = cpu_lock; lck[2] = dbg_lock;
        if (m_owner != 0 && req[m_owner] && lck[m_owner]
            && (m_held < MAX_BURST - 1 || !req[3 - m_owner]))
            return m_owner;
        if (req[1] && req[2]) return 3 - m_last;
        if (req[1]) return 1;
        if (req[2]) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_owner = 0; m_last = 2; m_held = 0; m_stall = 0;
    endtask

    task automatic model_step(input int w);
        bit lck[3];
        lck[0] = 1'b0; lck[1] = cpu_lock; lck[2] = dbg_lock;
        if (w != 0 && w == m_owner && lck[w]) m_held = (m_held + 1 > MAX_BURST - 1) ? MAX_BURST - 1 : m_held + 1;
        else m_held = 0;
        if (STATS && cpu_req && w != 1 && m_stall < 16'hFFFF) m_stall++;
        m_owner = w;
        if (w != 0) m_last = w;
    endtask

    // One clocked transaction: compare all outputs mid-cycle, then advance the model on the edge.
    task automatic cycle_chk();
        int w;
        @(negedge clk);
        w = model_winner();
        obs_gnt = {dbg_gnt, cpu_gnt};
        chk("cpu_gnt", cpu_gnt, w == 1);
        chk("dbg_gnt", dbg_gnt, w == 2);
        chk("cpu_stall", cpu_stall, cpu_req && w != 1);
        chk("dm_wr", dm_wr, w == 1 ? cpu_we : w == 2 ? dbg_we : 1'b0);
        chk("dm_addr", dm_addr, w == 1 ? cpu_addr : w == 2 ? dbg_addr : '0);
        chk("dm_din", dm_din, w == 1 ? cpu_wdata : w == 2 ? dbg_wdata : '0);
        chk("dm_memop", dm_memop, w == 1 ? cpu_memop : w == 2 ? dbg_memop : 2'd0);
        chk("rdata", rdata, dm_dout);
        chk("stall_cnt", stall_cnt, m_stall);
        @(posedge clk);
        model_step(w);
        #1;
    endtask

    task automatic drive_idle();
        cpu_req = 0; cpu_we = 0; cpu_lock = 0; cpu_addr = '0; cpu_wdata = '0; cpu_memop = MEMOP_WORD;
        dbg_req = 0; dbg_we = 0; dbg_lock = 0; dbg_addr = '0; dbg_wdata = '0; dbg_memop = MEMOP_WORD;
        dm_dout = '0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        string seq;
        drive_idle();
        rstn = 1'b0;
        model_reset();

        // Requests held through reset must not be granted.
        cpu_req = 1; dbg_req = 1; cpu_we = 1; cpu_addr = 7'h11;
        @(negedge clk);
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_dbg_gnt", dbg_gnt, 0);
        chk("rst_dm_wr", dm_wr, 0);
        chk("rst_dm_addr", dm_addr, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        cycle_chk();
        chk("first_tie", obs_gnt, 2'b01);

        // Single CPU write passes straight through.
        do_reset();
        drive_idle();
        cpu_req = 1; cpu_we = 1; cpu_addr = 7'h05; cpu_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("wr_gnt", cpu_gnt, 1);
        chk("wr_dm_wr", dm_wr, 1);
        chk("wr_addr", dm_addr, 7'h05);
        chk("wr_din", dm_din, 32'hDEADBEEF);
        chk("wr_dbg_gnt", dbg_gnt, 0);
        @(posedge clk); model_step(1); #1;

        // Unlocked contention alternates; every second cycle the CPU stalls.
        do_reset();
        drive_idle();
        cpu_req = 1; dbg_req = 1;
        for (int i = 0; i < 20; i++) begin
            cycle_chk();
            chk("alternate", obs_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        drive_idle();
        @(negedge clk);
        chk("stall_total", stall_cnt, STATS ? 16'd10 : 16'd0);

        // Debug burst lock against a waiting CPU, then uncontested.
        do_reset();
        drive_idle();
        cpu_req = 1; dbg_req = 1; dbg_lock = 1;
        seq = "CDDDDCDDDDC";
        for (int i = 0; i < seq.len(); i++) begin
            cycle_chk();
            chk("burst_seq", obs_gnt, (seq[i] == "C") ? 2'b01 : 2'b10);
        end
        cpu_req = 0;
        for (int i = 0; i < 10; i++) begin
            cycle_chk();
            chk("burst_solo", obs_gnt, 2'b10);
        end

        // Reset mid-burst drops the grant at once and restarts round-robin.
        do_reset();
        drive_idle();
        dbg_req = 1; dbg_lock = 1;
        repeat (3) cycle_chk();
        cpu_req = 1;
        rstn = 1'b0;
        model_reset();
        #1;
        chk("midrst_dbg_gnt", dbg_gnt, 0);
        chk("midrst_cpu_gnt", cpu_gnt, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        cycle_chk();
        chk("midrst_tie", obs_gnt, 2'b01);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cpu_req   = ($urandom_range(0, 9) < 7);
            dbg_req   = ($urandom_range(0, 9) < 7);
            cpu_lock  = ($urandom_range(0, 3) != 0);
            dbg_lock  = ($urandom_range(0, 3) != 0);
            cpu_we    = $urandom_range(0, 1);
            dbg_we    = $urandom_range(0, 1);
            cpu_addr  = ADDR_W'($urandom);
            dbg_addr  = ADDR_W'($urandom);
            cpu_wdata = $urandom;
            dbg_wdata = $urandom;
            cpu_memop = 2'($urandom_range(0, 2));
            dbg_memop = 2'($urandom_range(0, 2));
            dm_dout   = $urandom;
            cycle_chk();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
